// File: rtl/shape_draw_pkg.sv
// Shared types and constants for the shape drawing path (control, drawer, VGA wrapper).
// Coordinate and colour widths live here so every block on the bus agrees on them.
package shape_draw_pkg;

  localparam int COORD_W  = 11;
  localparam int COLOUR_W = 3;

  localparam logic [COLOUR_W-1:0] BLACK = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } draw_state_t;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shape_rect_drawer_if.sv
// Bus between game control (master) and the rectangle drawer (slave).
// Handshake: control raises draw_start with load_* stable and holds it until it
// sees draw_done; dropping draw_start early aborts the shape. send_* carry a pixel
// only on cycles where plot is high.
interface shape_rect_drawer_if;

  logic                                  draw_start;
  logic [shape_draw_pkg::COORD_W-1:0]    load_x;
  logic [shape_draw_pkg::COORD_W-1:0]    load_y;
  logic [shape_draw_pkg::COLOUR_W-1:0]   load_colour;
  logic [shape_draw_pkg::COORD_W-1:0]    send_x;
  logic [shape_draw_pkg::COORD_W-1:0]    send_y;
  logic [shape_draw_pkg::COLOUR_W-1:0]   send_colour;
  logic                                  plot;
  logic                                  draw_done;
  logic                                  busy;

  modport master (
    output draw_start, load_x, load_y, load_colour,
    input  send_x, send_y, send_colour, plot, draw_done, busy
  );

  modport slave (
    input  draw_start, load_x, load_y, load_colour,
    output send_x, send_y, send_colour, plot, draw_done, busy
  );

endinterface

// File: rtl/shape_rect_drawer_scanner.sv
// rect_scanner: row-major dx/dy offset counter for one WIDTH x HEIGHT pass.
// Wraps back to (0,0) after the last pixel so back-to-back passes need no extra clear.
module rect_scanner
  import shape_draw_pkg::*;
#(
  parameter  int WIDTH  = 10,
  parameter  int HEIGHT = 10,
  localparam int XW     = cnt_w(WIDTH),
  localparam int YW     = cnt_w(HEIGHT)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_start,
  input  logic          i_clear,
  input  logic          i_advance,
  output logic [XW-1:0] o_dx,
  output logic [YW-1:0] o_dy,
  output logic          o_last_pixel
);

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  logic [XW-1:0] r_dx;
  logic [YW-1:0] r_dy;
  logic          w_x_last;
  logic          w_y_last;

  assign w_x_last     = (r_dx == X_LAST);
  assign w_y_last     = (r_dy == Y_LAST);
  assign o_last_pixel = w_x_last && w_y_last;
  assign o_dx         = r_dx;
  assign o_dy         = r_dy;

  // Offset counter: restart on a new pass or abort, else step row-major.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dx <= '0;
      r_dy <= '0;
    end else if (i_start || i_clear) begin
      r_dx <= '0;
      r_dy <= '0;
    end else if (i_advance) begin
      if (w_x_last) begin
        r_dx <= '0;
        r_dy <= w_y_last ? '0 : r_dy + YW'(1);
      end else begin
        r_dx <= r_dx + XW'(1);
      end
    end
  end

endmodule

// File: rtl/shape_rect_drawer.sv
// shape_rect_drawer: scans a WIDTH x HEIGHT filled rectangle onto the VGA plot bus,
// one pixel per cycle, and reports completion with a level draw_done.
// Optional feature macro SHAPE_ERASE_TRAIL_EN: before each new shape, repaint the
// previously completed shape's footprint with BG_COLOUR.
// COORD_W / COLOUR_W come from shape_draw_pkg so they match control and the adapter.
module shape_rect_drawer
  import shape_draw_pkg::*;
#(
  parameter int                   WIDTH     = 10,
  parameter int                   HEIGHT    = 10,
  parameter logic [COLOUR_W-1:0]  BG_COLOUR = BLACK
) (
  input  logic                clock,
  input  logic                reset,
  shape_rect_drawer_if.slave  bus,
  output draw_state_t         o_dbg_state
);

  localparam int XW = cnt_w(WIDTH);
  localparam int YW = cnt_w(HEIGHT);

  draw_state_t         r_state;
  draw_state_t         w_next;

  logic [COORD_W-1:0]  r_bx;
  logic [COORD_W-1:0]  r_by;
  logic [COLOUR_W-1:0] r_col;

  logic [COORD_W-1:0]  r_send_x;
  logic [COORD_W-1:0]  r_send_y;
  logic [COLOUR_W-1:0] r_send_col;
  logic                r_plot;
  logic                r_done;

  logic                w_latch;
  logic                w_scan_start;
  logic                w_scan_clear;
  logic                w_advance;
  logic                w_emit;
  logic                w_set_prev;
  logic                w_last;
  logic                w_erasing;
  logic [XW-1:0]       w_dx;
  logic [YW-1:0]       w_dy;
  logic [COORD_W-1:0]  w_org_x;
  logic [COORD_W-1:0]  w_org_y;
  logic [COLOUR_W-1:0] w_pix_col;

  rect_scanner #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_scanner (
    .clock        (clock),
    .reset        (reset),
    .i_start      (w_scan_start),
    .i_clear      (w_scan_clear),
    .i_advance    (w_advance),
    .o_dx         (w_dx),
    .o_dy         (w_dy),
    .o_last_pixel (w_last)
  );

`ifdef SHAPE_ERASE_TRAIL_EN
  logic [COORD_W-1:0] r_prev_x;
  logic [COORD_W-1:0] r_prev_y;
  logic               r_prev_valid;

  assign w_erasing = (r_state == ERASE);
  assign w_org_x   = w_erasing ? r_prev_x : r_bx;
  assign w_org_y   = w_erasing ? r_prev_y : r_by;

  // Remember the origin of the last fully drawn shape for the next erase pass.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prev_x     <= '0;
      r_prev_y     <= '0;
      r_prev_valid <= 1'b0;
    end else if (w_set_prev) begin
      r_prev_x     <= r_bx;
      r_prev_y     <= r_by;
      r_prev_valid <= 1'b1;
    end
  end
`else
  assign w_erasing = 1'b0;
  assign w_org_x   = r_bx;
  assign w_org_y   = r_by;
`endif

  assign w_pix_col = w_erasing ? BG_COLOUR : r_col;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state and per-cycle control strobes; a dropped draw_start aborts any pass.
  always_comb begin
    w_next       = r_state;
    w_latch      = 1'b0;
    w_scan_start = 1'b0;
    w_scan_clear = 1'b0;
    w_advance    = 1'b0;
    w_emit       = 1'b0;
    w_set_prev   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.draw_start) begin
          w_latch      = 1'b1;
          w_scan_start = 1'b1;
`ifdef SHAPE_ERASE_TRAIL_EN
          w_next       = r_prev_valid ? ERASE : DRAW;
`else
          w_next       = DRAW;
`endif
        end
      end
`ifdef SHAPE_ERASE_TRAIL_EN
      ERASE: begin
        if (!bus.draw_start) begin
          w_scan_clear = 1'b1;
          w_next       = IDLE;
        end else begin
          w_emit    = 1'b1;
          w_advance = 1'b1;
          if (w_last) begin
            w_scan_clear = 1'b1;
            w_next       = DRAW;
          end
        end
      end
`endif
      DRAW: begin
        if (!bus.draw_start) begin
          w_scan_clear = 1'b1;
          w_next       = IDLE;
        end else begin
          w_emit    = 1'b1;
          w_advance = 1'b1;
          if (w_last) begin
            w_set_prev = 1'b1;
            w_next     = DONE;
          end
        end
      end
      DONE: begin
        if (!bus.draw_start) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Shape origin and colour are captured only when a request is accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_bx  <= '0;
      r_by  <= '0;
      r_col <= '0;
    end else if (w_latch) begin
      r_bx  <= bus.load_x;
      r_by  <= bus.load_y;
      r_col <= bus.load_colour;
    end
  end

  // Registered plot bus; coordinates wrap modulo 2^COORD_W, no clipping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_send_x   <= '0;
      r_send_y   <= '0;
      r_send_col <= '0;
      r_plot     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_plot <= w_emit;
      r_done <= (r_state == DONE) && bus.draw_start;
      if (w_emit) begin
        r_send_x   <= w_org_x + COORD_W'(w_dx);
        r_send_y   <= w_org_y + COORD_W'(w_dy);
        r_send_col <= w_pix_col;
      end
    end
  end

  assign bus.send_x      = r_send_x;
  assign bus.send_y      = r_send_y;
  assign bus.send_colour = r_send_col;
  assign bus.plot        = r_plot;
  assign bus.draw_done   = r_done;
  assign bus.busy        = (r_state == ERASE) || (r_state == DRAW);
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_shape_rect_drawer.sv
// Bench for shape_rect_drawer: a 2x2 instance checked every cycle against a
// pixel-queue model plus literal checks, and a 1x1 instance with literal checks.
module tb_shape_rect_drawer;
  import shape_draw_pkg::*;

  localparam int MW = 2;
  localparam int MH = 2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  shape_rect_drawer_if if_a ();
  shape_rect_drawer_if if_b ();
  draw_state_t dbg_a;
  draw_state_t dbg_b;

  shape_rect_drawer #(.WIDTH(MW), .HEIGHT(MH)) u_a (
    .clock       (clock),
    .reset       (reset),
    .bus         (if_a),
    .o_dbg_state (dbg_a)
  );

  shape_rect_drawer #(.WIDTH(1), .HEIGHT(1)) u_b (
    .clock       (clock),
    .reset       (reset),
    .bus         (if_b),
    .o_dbg_state (dbg_b)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model of instance A ----------------
  typedef struct packed {
    logic                er;
    logic [COORD_W-1:0]  x;
    logic [COORD_W-1:0]  y;
    logic [COLOUR_W-1:0] c;
  } pix_t;

  pix_t                exp_q[$];
  int                  m_mode = 0;   // 0 waiting, 1 pixels pending, 2 finished
  logic                m_prev_valid = 1'b0;
  logic [COORD_W-1:0]  m_prev_x = '0;
  logic [COORD_W-1:0]  m_prev_y = '0;
  logic [COORD_W-1:0]  m_org_x = '0;
  logic [COORD_W-1:0]  m_org_y = '0;
  logic                exp_plot = 1'b0;
  logic [COORD_W-1:0]  exp_x = '0;
  logic [COORD_W-1:0]  exp_y = '0;
  logic [COLOUR_W-1:0] exp_c = '0;
  logic                exp_done = 1'b0;
  logic                exp_busy = 1'b0;
  draw_state_t         exp_state = IDLE;

  function automatic draw_state_t pass_of(input pix_t p);
    return p.er ? ERASE : DRAW;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      m_mode = 0; m_prev_valid = 1'b0; m_prev_x = '0; m_prev_y = '0;
      exp_plot = 1'b0; exp_x = '0; exp_y = '0; exp_c = '0;
      exp_done = 1'b0; exp_busy = 1'b0; exp_state = IDLE;
    end else begin
      case (m_mode)
        0: begin
          exp_plot = 1'b0; exp_done = 1'b0; exp_busy = 1'b0; exp_state = IDLE;
          if (if_a.draw_start) begin
            m_org_x = if_a.load_x;
            m_org_y = if_a.load_y;
`ifdef SHAPE_ERASE_TRAIL_EN
            if (m_prev_valid)
              for (int j = 0; j < MH; j++)
                for (int i = 0; i < MW; i++)
                  exp_q.push_back({1'b1, COORD_W'(m_prev_x + i), COORD_W'(m_prev_y + j), BLACK});
`endif
            for (int j = 0; j < MH; j++)
              for (int i = 0; i < MW; i++)
                exp_q.push_back({1'b0, COORD_W'(m_org_x + i), COORD_W'(m_org_y + j), if_a.load_colour});
            m_mode = 1; exp_busy = 1'b1; exp_state = pass_of(exp_q[0]);
          end
        end
        1: begin
          if (!if_a.draw_start) begin
            exp_q.delete();
            m_mode = 0; exp_plot = 1'b0; exp_busy = 1'b0; exp_state = IDLE;
          end else begin
            pix_t p;
            p = exp_q.pop_front();
            exp_plot = 1'b1; exp_x = p.x; exp_y = p.y; exp_c = p.c;
            if (exp_q.size() == 0) begin
              m_mode = 2; exp_busy = 1'b0; exp_state = DONE;
              m_prev_valid = 1'b1; m_prev_x = m_org_x; m_prev_y = m_org_y;
            end else begin
              exp_busy = 1'b1; exp_state = pass_of(exp_q[0]);
            end
          end
        end
        default: begin
          exp_plot = 1'b0;
          if (if_a.draw_start) exp_done = 1'b1;
          else begin
            m_mode = 0; exp_done = 1'b0; exp_state = IDLE;
          end
        end
      endcase
    end
  end

  // Per-cycle compare of instance A, sampled after outputs settle.
  always @(posedge clock) begin
    #2;
    if (!reset) begin
      check("a_plot", 32'(if_a.plot), 32'(exp_plot));
      check("a_done", 32'(if_a.draw_done), 32'(exp_done));
      check("a_busy", 32'(if_a.busy), 32'(exp_busy));
      check("a_state", 32'(dbg_a), 32'(exp_state));
      if (exp_plot) begin
        check("a_x", 32'(if_a.send_x), 32'(exp_x));
        check("a_y", 32'(if_a.send_y), 32'(exp_y));
        check("a_col", 32'(if_a.send_colour), 32'(exp_c));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic start_a(input int x, input int y, input int c);
    if_a.load_x      = COORD_W'(x);
    if_a.load_y      = COORD_W'(y);
    if_a.load_colour = COLOUR_W'(c);
    if_a.draw_start  = 1'b1;
  endtask

  task automatic pix_a(input string name, input int x, input int y, input int c);
    tick();
    check({name, "_plot"}, 32'(if_a.plot), 32'd1);
    check({name, "_x"}, 32'(if_a.send_x), 32'(x));
    check({name, "_y"}, 32'(if_a.send_y), 32'(y));
    check({name, "_col"}, 32'(if_a.send_colour), 32'(c));
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    if_a.draw_start = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    if_a.draw_start = 1'b0; if_a.load_x = '0; if_a.load_y = '0; if_a.load_colour = '0;
    // B requests already while in reset
    if_b.draw_start = 1'b1; if_b.load_x = 11'd100; if_b.load_y = 11'd200; if_b.load_colour = 3'd4;
    repeat (3) tick();
    check("rst_a_plot", 32'(if_a.plot), 32'd0);
    check("rst_a_done", 32'(if_a.draw_done), 32'd0);
    check("rst_a_busy", 32'(if_a.busy), 32'd0);
    check("rst_a_x", 32'(if_a.send_x), 32'd0);
    check("rst_a_state", 32'(dbg_a), 32'(IDLE));
    reset = 1'b0;

    // 1x1 with start held across reset release
    tick();
    check("b_acc_busy", 32'(if_b.busy), 32'd1);
    check("b_acc_plot", 32'(if_b.plot), 32'd0);
    tick();
    check("b_pix_plot", 32'(if_b.plot), 32'd1);
    check("b_pix_x", 32'(if_b.send_x), 32'd100);
    check("b_pix_y", 32'(if_b.send_y), 32'd200);
    check("b_pix_col", 32'(if_b.send_colour), 32'd4);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("b_hold_done", 32'(if_b.draw_done), 32'd1);
      check("b_hold_plot", 32'(if_b.plot), 32'd0);
    end
    if_b.draw_start = 1'b0;
    tick();
    check("b_drop_done", 32'(if_b.draw_done), 32'd0);
    check("b_drop_state", 32'(dbg_b), 32'(IDLE));
    if_b.load_x = 11'd7; if_b.load_y = 11'd9; if_b.load_colour = 3'd1; if_b.draw_start = 1'b1;
    tick();
    tick();
    check("b_re_plot", 32'(if_b.plot), 32'd1);
    check("b_re_x", 32'(if_b.send_x), 32'd7);
    check("b_re_y", 32'(if_b.send_y), 32'd9);
    tick();
    check("b_re_done", 32'(if_b.draw_done), 32'd1);
    if_b.draw_start = 1'b0;

    // 2x2 at (5,7) colour 3
    start_a(5, 7, 3);
    tick();
    check("t1_busy", 32'(if_a.busy), 32'd1);
    pix_a("t1_p0", 5, 7, 3);
    pix_a("t1_p1", 6, 7, 3);
    pix_a("t1_p2", 5, 8, 3);
    pix_a("t1_p3", 6, 8, 3);
    tick();
    check("t1_done", 32'(if_a.draw_done), 32'd1);
    check("t1_done_plot", 32'(if_a.plot), 32'd0);
    tick();
    check("t1_done_held", 32'(if_a.draw_done), 32'd1);
    if_a.draw_start = 1'b0;
    tick();
    check("t1_done_clr", 32'(if_a.draw_done), 32'd0);

    // abort after second pixel, then a fresh request
    do_reset();
    start_a(10, 20, 5);
    tick();
    pix_a("t2_p0", 10, 20, 5);
    pix_a("t2_p1", 11, 20, 5);
    if_a.draw_start = 1'b0;
    tick();
    check("t2_abort_plot", 32'(if_a.plot), 32'd0);
    check("t2_abort_done", 32'(if_a.draw_done), 32'd0);
    check("t2_abort_state", 32'(dbg_a), 32'(IDLE));
    tick();
    start_a(30, 40, 6);
    tick();
    if_a.load_x = 11'd999; if_a.load_colour = 3'd1;
    pix_a("t2_r0", 30, 40, 6);
    pix_a("t2_r1", 31, 40, 6);
    pix_a("t2_r2", 30, 41, 6);
    pix_a("t2_r3", 31, 41, 6);
    tick();
    check("t2_done", 32'(if_a.draw_done), 32'd1);
    if_a.draw_start = 1'b0;
    tick();

    // coordinate wrap at 2^11
    do_reset();
    start_a(2047, 2047, 7);
    tick();
    pix_a("t3_p0", 2047, 2047, 7);
    pix_a("t3_p1", 0, 2047, 7);
    pix_a("t3_p2", 2047, 0, 7);
    pix_a("t3_p3", 0, 0, 7);
    tick();
    check("t3_done", 32'(if_a.draw_done), 32'd1);
    if_a.draw_start = 1'b0;
    tick();

    // async reset mid-scan
    do_reset();
    start_a(50, 60, 2);
    tick();
    pix_a("t4_p0", 50, 60, 2);
    #1;
    reset = 1'b1;
    if_a.draw_start = 1'b0;
    #1;
    check("t4_plot", 32'(if_a.plot), 32'd0);
    check("t4_done", 32'(if_a.draw_done), 32'd0);
    check("t4_busy", 32'(if_a.busy), 32'd0);
    check("t4_x", 32'(if_a.send_x), 32'd0);
    check("t4_y", 32'(if_a.send_y), 32'd0);
    check("t4_col", 32'(if_a.send_colour), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("t4_idle", 32'(dbg_a), 32'(IDLE));
    check("t4_idle_plot", 32'(if_a.plot), 32'd0);

`ifdef SHAPE_ERASE_TRAIL_EN
    // erase trail: (0,0) then (3,0)
    do_reset();
    start_a(0, 0, 2);
    tick();
    pix_a("t5_a0", 0, 0, 2);
    pix_a("t5_a1", 1, 0, 2);
    pix_a("t5_a2", 0, 1, 2);
    pix_a("t5_a3", 1, 1, 2);
    tick();
    if_a.draw_start = 1'b0;
    tick();
    start_a(3, 0, 6);
    tick();
    pix_a("t5_e0", 0, 0, 0);
    pix_a("t5_e1", 1, 0, 0);
    pix_a("t5_e2", 0, 1, 0);
    pix_a("t5_e3", 1, 1, 0);
    pix_a("t5_d0", 3, 0, 6);
    pix_a("t5_d1", 4, 0, 6);
    pix_a("t5_d2", 3, 1, 6);
    pix_a("t5_d3", 4, 1, 6);
    tick();
    check("t5_done", 32'(if_a.draw_done), 32'd1);
    if_a.draw_start = 1'b0;
    tick();
`endif

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
